scan_decoder: RTL and testbench

//   Registered, parametrised SEL_W-to-2**SEL_W one-hot decoder with enable, and two modes:
//   - MANUAL: an index is loaded through a valid/ready handshake.
//   - SCAN: an internal counter walks the outputs, holding each one for DWELL cycles.

---
 rtl/scan_decoder_pkg.sv | 26 ++
 rtl/scan_decoder_dwell_timer.sv | 30 +++
 rtl/scan_decoder.sv | 81 ++++++++
 tb/tb_scan_decoder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/scan_decoder_pkg.sv
// Shared definitions for the scan decoder: state encoding, output count
// derivation and a one-hot helper.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_t;

  // Widest decoder supported by the one-hot helper (2**8 outputs).
  localparam int unsigned MAX_SEL_W = 8;
  localparam int unsigned MAX_N_OUT = 1 << MAX_SEL_W;

  function automatic int unsigned n_out(input int unsigned sel_w);
    return 32'd1 << sel_w;
  endfunction

  function automatic logic [MAX_N_OUT-1:0] onehot(input int unsigned idx);
    logic [MAX_N_OUT-1:0] v;
    v = '0;
    v[idx[MAX_SEL_W-1:0]] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/scan_decoder_dwell_timer.sv
// Dwell timer: pulses tick once every DWELL cycles while run is high and
// restarts from zero whenever run drops.
module dwell_timer #(
  parameter int unsigned DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = run && (cnt_q == CW'(DWELL - 1));

  // Next count: wrap on tick, hold at zero while not running.
  always_comb begin
    cnt_d = '0;
    if (run && !tick) cnt_d = cnt_q + 1'b1;
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with enable, manual (valid/ready) and scan modes.
module scan_decoder
  import decoder_pkg::*;
#(
  parameter int unsigned SEL_W = 2,
  parameter int unsigned DWELL = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      mode,
  input  logic                      sel_valid,
  input  logic [SEL_W-1:0]          sel,
  output logic                      sel_ready,
  output logic [n_out(SEL_W)-1:0]   dout,
  output logic [SEL_W-1:0]          idx,
  output logic                      wrap
);

  localparam int unsigned N_OUT = n_out(SEL_W);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [N_OUT-1:0]   dout_q, dout_d;
  logic               wrap_q, wrap_d;
  logic               run, tick;

  // The entry edge into SCAN has run=0, so the timer starts at zero there and
  // the first advance lands DWELL edges after entry.
  assign run       = (state_q == SCAN) && en && mode;
  assign sel_ready = rst_n && en && !mode;

  dwell_timer #(.DWELL(DWELL)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .tick  (tick)
  );

  // Next state and registered outputs, re-evaluated every cycle from en/mode.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dout_d  = '0;
    wrap_d  = 1'b0;
    if (!en) begin
      state_d = IDLE;
    end else if (!mode) begin
      state_d = MANUAL;
      if (sel_valid) idx_d = sel;
      dout_d = N_OUT'(onehot(32'(idx_d)));
    end else begin
      state_d = SCAN;
      if (tick) begin
        idx_d  = idx_q + 1'b1;
        wrap_d = (idx_q == '1);
      end
      dout_d = N_OUT'(onehot(32'(idx_d)));
    end
  end

  // FSM and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dout_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dout_q  <= dout_d;
      wrap_q  <= wrap_d;
    end
  end

  assign dout = dout_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: table vectors, hand corner sequences and a random
// phase checked against a cycle-level behavioural model, on two configurations.
module tb_scan_decoder;

  logic       clk = 1'b0;
  logic       rst_n, en, mode, sel_valid;
  logic [1:0] sel_a;
  logic [2:0] sel_b;
  logic       rdy_a, rdy_b, wrap_a, wrap_b;
  logic [3:0] dout_a;
  logic [7:0] dout_b;
  logic [1:0] idx_a;
  logic [2:0] idx_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  scan_decoder #(.SEL_W(2), .DWELL(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_valid(sel_valid),
    .sel(sel_a), .sel_ready(rdy_a), .dout(dout_a), .idx(idx_a), .wrap(wrap_a));

  scan_decoder #(.SEL_W(3), .DWELL(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_valid(sel_valid),
    .sel(sel_b), .sel_ready(rdy_b), .dout(dout_b), .idx(idx_b), .wrap(wrap_b));

  // Behavioural model, index 0 = dut_a, 1 = dut_b.
  int m_idx[2], m_dout[2], m_wrap[2], m_age[2];
  bit m_scan[2];
  int m_nout[2]  = '{4, 8};
  int m_dwell[2] = '{4, 1};

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Outcome of one clock edge: age counts edges since SCAN was entered and
  // the index moves on every DWELL-th such edge.
  task automatic model_edge(input int k, input int s);
    if (!rst_n) begin
      m_idx[k] = 0; m_dout[k] = 0; m_wrap[k] = 0; m_scan[k] = 0; m_age[k] = 0;
    end else if (!en) begin
      m_dout[k] = 0; m_wrap[k] = 0; m_scan[k] = 0;
    end else if (!mode) begin
      if (sel_valid) m_idx[k] = s;
      m_dout[k] = 1 << m_idx[k]; m_wrap[k] = 0; m_scan[k] = 0;
    end else begin
      m_wrap[k] = 0;
      if (!m_scan[k]) begin
        m_scan[k] = 1; m_age[k] = 0;
      end else begin
        m_age[k]++;
        if (m_age[k] % m_dwell[k] == 0) begin
          m_wrap[k] = (m_idx[k] == m_nout[k] - 1) ? 1 : 0;
          m_idx[k]  = (m_idx[k] + 1) % m_nout[k];
        end
      end
      m_dout[k] = 1 << m_idx[k];
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0, int'(sel_a));
    model_edge(1, int'(sel_b));
    #1;
    chk("a_dout", int'(dout_a), m_dout[0]);
    chk("a_idx",  int'(idx_a),  m_idx[0]);
    chk("a_wrap", int'(wrap_a), m_wrap[0]);
    chk("a_rdy",  int'(rdy_a),  (rst_n && en && !mode) ? 1 : 0);
    chk("b_dout", int'(dout_b), m_dout[1]);
    chk("b_idx",  int'(idx_b),  m_idx[1]);
    chk("b_wrap", int'(wrap_b), m_wrap[1]);
    chk("b_rdy",  int'(rdy_b),  (rst_n && en && !mode) ? 1 : 0);
  endtask

  typedef struct {
    logic       r, e, m, v;
    logic [1:0] s;
    logic [3:0] d;
    logic [1:0] i;
    logic       w;
  } vec_t;

  vec_t tbl[20];

  initial begin
    int wraps;
    rst_n = 1'b0; en = 1'b1; mode = 1'b1; sel_valid = 1'b0; sel_a = '0; sel_b = '0;

    // Expected dut_a outputs after each edge (SEL_W=2, DWELL=4).
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0100, 2'd2, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 4'b1000, 2'd3, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 4'b1000, 2'd3, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0000, 2'd3, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 4'b1000, 2'd3, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 4'b1000, 2'd3, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'b1000, 2'd3, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'b1000, 2'd3, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0001, 2'd0, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0001, 2'd0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0001, 2'd0, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0001, 2'd0, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0001, 2'd0, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0001, 2'd0, 1'b0};
    tbl[16] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0001, 2'd0, 1'b0};
    tbl[17] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0010, 2'd1, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 2'd1, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0000, 2'd0, 1'b0};

    for (int j = 0; j < 20; j++) begin
      rst_n = tbl[j].r; en = tbl[j].e; mode = tbl[j].m; sel_valid = tbl[j].v;
      sel_a = tbl[j].s; sel_b = {1'b0, tbl[j].s};
      step();
      chk($sformatf("tbl%0d_dout", j), int'(dout_a), int'(tbl[j].d));
      chk($sformatf("tbl%0d_idx",  j), int'(idx_a),  int'(tbl[j].i));
      chk($sformatf("tbl%0d_wrap", j), int'(wrap_a), int'(tbl[j].w));
    end

    // Enable drop in SCAN at idx=2, then re-enable for a full dwell.
    rst_n = 1'b1; en = 1'b1; mode = 1'b0; sel_valid = 1'b1; sel_a = 2'd2; sel_b = 3'd2;
    step();
    mode = 1'b1; sel_valid = 1'b0;
    repeat (3) step();
    en = 1'b0;
    step();
    chk("drop_dout", int'(dout_a), 0);
    chk("drop_idx",  int'(idx_a),  2);
    en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("reen%0d_dout", c), int'(dout_a), 4);
    end
    step();
    chk("reen_adv_dout", int'(dout_a), 8);

    // Mid-scan reset at idx=3, dwell_cnt=2; no load while held in reset.
    mode = 1'b0; sel_valid = 1'b1; sel_a = 2'd3; sel_b = 3'd3;
    step();
    mode = 1'b1; sel_valid = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    step();
    chk("rst_dout", int'(dout_a), 0);
    chk("rst_idx",  int'(idx_a),  0);
    chk("rst_wrap", int'(wrap_a), 0);
    en = 1'b0; mode = 1'b0; sel_valid = 1'b1; sel_a = 2'd2; sel_b = 3'd5;
    step();
    chk("rst_noload_a", int'(idx_a), 0);
    chk("rst_noload_b", int'(idx_b), 0);

    // DWELL=1, SEL_W=3: advance every cycle, wrap every 8th, sel ignored.
    rst_n = 1'b1; en = 1'b1; mode = 1'b1;
    wraps = 0;
    for (int k = 0; k <= 16; k++) begin
      sel_valid = 1'b1; sel_b = 3'($urandom_range(0, 7)); sel_a = 2'($urandom_range(0, 3));
      step();
      chk($sformatf("d1_idx%0d", k), int'(idx_b), k % 8);
      if (wrap_b) wraps++;
    end
    chk("d1_wraps", wraps, 2);

    // Randomised phase against the model.
    for (int n = 0; n < 600; n++) begin
      rst_n     = ($urandom_range(0, 49) != 0);
      en        = ($urandom_range(0, 9) != 0);
      mode      = ($urandom_range(0, 99) < 60);
      sel_valid = $urandom_range(0, 1);
      sel_a     = 2'($urandom_range(0, 3));
      sel_b     = 3'($urandom_range(0, 7));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
